// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encoding.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_POR  = 2'b01,
        CAUSE_SW   = 2'b10,
        CAUSE_WDT  = 2'b11
    } cause_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-stage reset synchronizer: asserts asynchronously, deasserts on the
// second rising clock edge after the reset input falls.
module reset_sync (
    input  logic clock,
    input  logic reset,
    output logic sync_reset
);

    logic stage1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage1     <= 1'b1;
            sync_reset <= 1'b1;
        end else begin
            stage1     <= 1'b0;
            sync_reset <= stage1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: asserts all domain resets together, releases them
// in ascending order with programmable gaps. Cause register under RESET_SEQ_CAUSE_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS  = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int DELAY_CYCLES = 4
) (
    input  logic                   _iClk,
    input  logic                   _iReset,
    input  logic                   _iSwReq,
    input  logic                   _iWdtExpire,
    input  logic                   _iCauseClr,
    output logic [NUM_DOMAINS-1:0] _oDomainReset,
    output logic                   _oBusy,
    output logic [1:0]             _oResetCause
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, DELAY_CYCLES) + 1);
    localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;

    logic                   sync_rst;
    logic                   reset_event;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   busy_q, busy_d;

    reset_sync u_reset_sync (
        .clock      (_iClk),
        .reset      (_iReset),
        .sync_reset (sync_rst)
    );

    assign reset_event = _iSwReq | _iWdtExpire;

    // Board reset asserts everything at once; the synchronized copy only
    // holds the sequencer idle until its release is safely clocked.
    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            busy_q  <= 1'b1;
        end else if (sync_rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        busy_d  = busy_q;

        case (state_q)
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    dom_d[0] = 1'b0;
                    cnt_d    = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            dom_d[i] = 1'b0;
                        end
                    end
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                dom_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                dom_d   = '1;
                busy_d  = 1'b1;
            end
        endcase

        // A request from any state restarts the whole sequence.
        if (reset_event) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            busy_d  = 1'b1;
        end
    end

    assign _oDomainReset = dom_q;
    assign _oBusy        = busy_q;

`ifdef RESET_SEQ_CAUSE_EN
    cause_e cause_q;

    // Watchdog outranks software, and any new event outranks a clear.
    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            cause_q <= CAUSE_POR;
        end else if (sync_rst) begin
            cause_q <= CAUSE_POR;
        end else if (_iWdtExpire) begin
            cause_q <= CAUSE_WDT;
        end else if (_iSwReq) begin
            cause_q <= CAUSE_SW;
        end else if (_iCauseClr && (state_q == RUN)) begin
            cause_q <= CAUSE_NONE;
        end
    end

    assign _oResetCause = cause_q;
`else
    logic unused_cause_clr;

    assign unused_cause_clr = _iCauseClr;
    assign _oResetCause     = CAUSE_NONE;
`endif

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Central reset controller that sequences the release of per-subsystem resets after power-on, software-requested or watchdog reset events. All domain resets assert together. They release one at a time in ascending index order, with programmable gaps. The block sits at the top level between the board reset input and every subsystem's reset port. It also records the cause of the last reset for firmware.

## Interface
- NUM_DOMAINS, 4, number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 8, cycles all resets stay asserted after the reset event ends (≥1)
- DELAY_CYCLES, 4, cycles between consecutive domain releases (≥1)

Ports (clock and reset first):
- _iClk  input  1  clock
- _iReset  input  1  reset, asynchronous, active-high
- _iSwReq  input  1  software reset request; any cycle sampled high triggers
- _iWdtExpire  input  1  watchdog expiry; any cycle sampled high triggers
- _iCauseClr  input  1  clears the cause register
- _oDomainReset  output  NUM_DOMAINS  per-domain reset, active-high
- _oBusy  output  1  high while any domain reset is asserted
- _oResetCause  output  2  00 none, 01 POR, 10 SW, 11 WDT

## Operation
- States: HOLD, RELEASE, RUN.
- Counter width is $clog2(max(HOLD_CYCLES, DELAY_CYCLES)+1). Release index width is $clog2(NUM_DOMAINS)+1.
- **_iReset high (async):** the following apply immediately, with no clock edge:
  - _oDomainReset = all ones, _oBusy = 1.
  - State = HOLD, counter = 0, index = 0.
  - _oResetCause = 01.
- _iReset deassertion passes through an internal two-stage synchronizer. The internal reset falls on the second rising edge after _iReset falls.
- **HOLD:** counter increments each edge. On the edge where counter == HOLD_CYCLES-1:
  - Clear _oDomainReset[0] and zero the counter.
  - If NUM_DOMAINS == 1, go to RUN; otherwise go to RELEASE with index = 1.
- **RELEASE:** counter increments. On the edge where counter == DELAY_CYCLES-1:
  - Clear _oDomainReset[index], zero the counter and increment index.
  - After clearing bit NUM_DOMAINS-1, go to RUN.
  - Released bits stay low; resets never release out of order.
- **RUN:** _oDomainReset = 0, _oBusy = 0.
- **Reset events (_iSwReq or _iWdtExpire high at an edge, any state):**
  - On that same edge: _oDomainReset = all ones, _oBusy = 1, state = HOLD, counter = 0, index = 0.
  - A request during HOLD restarts the hold count.
  - A request held high keeps the block in HOLD.
- **Cause register:**
  - Set to 10 by SW and to 11 by WDT.
  - SW and WDT on the same edge set 11; WDT has priority.
  - _iCauseClr clears the register to 00 only in RUN.
  - A reset event on the same edge as _iCauseClr wins over the clear.

## Timing
- Edges are counted from the _iReset fall, edge 1 being the first rising edge after it:
  - Internal reset deasserts at edge 2.
  - Domain k deasserts at edge 2 + HOLD_CYCLES + k·DELAY_CYCLES.
- SW/WDT sampled at edge N:
  - All resets are high after edge N.
  - Domain k deasserts at edge N + HOLD_CYCLES + k·DELAY_CYCLES.
- _oBusy falls on the same edge as the last domain release.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro RESET_SEQ_CAUSE_EN.
- **Defined:** the cause register and _iCauseClr behave as described.
- **Undefined:**
  - No cause register is built and _oResetCause is tied to 2'b00.
  - _iCauseClr is ignored.
  - Sequencing is unchanged.

## Structure
- Package reset_seq_pkg holds:
  - the state enum (HOLD, RELEASE, RUN);
  - the cause enum (CAUSE_NONE=2'b00, CAUSE_POR=2'b01, CAUSE_SW=2'b10, CAUSE_WDT=2'b11).
- One sub-module: the existing reset_sync two-stage synchronizer, driven by _iClk/_iReset. Its output is the internal reset for the state machine.
- Asynchronous assertion of the outputs comes directly from _iReset, not from the synchronizer output.

## Test plan
Parameters: NUM_DOMAINS=4, HOLD_CYCLES=8, DELAY_CYCLES=4.
- **POR:** pulse _iReset, then release -> all resets high throughout; domains 0..3 fall at edges 10, 14, 18, 22; _oBusy falls at 22; cause = 01.
- **SW in RUN:** _iSwReq high for 1 cycle at edge N -> all resets high after N; domains fall at N+8, N+12, N+16, N+20; cause = 10.
- **WDT mid-RELEASE (domains 0, 1 released):** _iWdtExpire at edge N -> all four domains re-asserted after N; full sequence restarts; cause = 11.
- **SW and WDT on the same edge:** cause = 11.
- **Cause clear precedence:** _iCauseClr together with _iSwReq -> cause = 10. _iCauseClr alone in RUN -> 00. _iCauseClr during HOLD -> unchanged. With the macro undefined, cause is always 00.
- **Async reset mid-RELEASE:** _iReset raised between edges -> all outputs high before the next edge; cause = 01; sequence restarts per the POR timing.
